// File: rtl/parity_frame_scheduler_if.sv
// Requester-side bundle for the parity frame scheduler.
// master: requesters plus line observer; slave: the scheduler.
interface parity_frame_scheduler_if;
  logic [1:0] req;
  logic [3:0] data0;
  logic [3:0] data1;
  logic [1:0] gnt;
  logic       tx;
  logic       busy;
  logic       done;
  logic       src;

  modport master (
    output req, data0, data1,
    input  gnt, tx, busy, done, src
  );

  modport slave (
    input  req, data0, data1,
    output gnt, tx, busy, done, src
  );
endinterface

// File: rtl/parity_frame_scheduler.sv
// Two-requester odd-parity nibble framer: start, 4 data LSB first, parity, stop.
// Define PARITY_SCHED_RR_EN for round-robin; default is fixed priority (req[0]).
module parity_frame_scheduler #(
  parameter int BIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  parity_frame_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  state_t     state_q, state_n;
  logic [7:0] cnt_q, cnt_n;
  logic [1:0] bit_q, bit_n;
  logic [3:0] shift_q, shift_n;
  logic       par_q, par_n;
  logic       tx_q, tx_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic [1:0] gnt_q, gnt_n;
  logic       src_q, src_n;

  logic       last;
  logic       any_req;
  logic       win;
  logic [3:0] win_data;
  logic       do_grant;

  assign last    = (cnt_q == LAST);
  assign any_req = |bus.req;

  // Pick the winner among the current requests.
  always_comb begin
`ifdef PARITY_SCHED_RR_EN
    win = (&bus.req) ? ~src_q : bus.req[1];
`else
    win = ~bus.req[0];
`endif
    win_data = win ? bus.data1 : bus.data0;
  end

  // Frame sequencer: next state and next registered outputs.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    par_n    = par_q;
    tx_n     = tx_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    gnt_n    = 2'b00;
    src_n    = src_q;
    do_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        cnt_n  = 8'd0;
        if (any_req) do_grant = 1'b1;
      end
      START: begin
        if (last) begin
          state_n = DATA;
          cnt_n   = 8'd0;
          bit_n   = 2'd0;
          tx_n    = shift_q[0];
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = 8'd0;
          if (bit_q == 2'd3) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            bit_n   = bit_q + 2'd1;
            shift_n = {1'b0, shift_q[3:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (last) begin
          state_n = STOP;
          cnt_n   = 8'd0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (last) begin
          done_n = 1'b1;
          cnt_n  = 8'd0;
          if (any_req) begin
            do_grant = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    if (do_grant) begin
      state_n = START;
      cnt_n   = 8'd0;
      bit_n   = 2'd0;
      shift_n = win_data;
      par_n   = ~^win_data;
      gnt_n   = win ? 2'b10 : 2'b01;
      src_n   = win;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
    end
  end

  // State and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 2'd0;
      shift_q <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gnt_q   <= 2'b00;
      src_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      gnt_q   <= gnt_n;
      src_q   <= src_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.src  = src_q;

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Scoreboard bench: predicted frames are queued at request time and
// checked bit by bit against the serial line of each instance.
module tb_parity_frame_scheduler;

  localparam int BA = 1;
  localparam int BB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_frame_scheduler_if ia ();
  parity_frame_scheduler_if ib ();

  parity_frame_scheduler #(.BIT_CYCLES(BA)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  parity_frame_scheduler #(.BIT_CYCLES(BB)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  typedef struct packed {
    logic [1:0] g;
    logic [3:0] nib;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur[2];
  int   act[2];
  int   pos[2];
  int   ones[2];
  logic msrc[2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  tag, obs, want, $time);
  endtask

  function automatic logic pick(input int u, input logic [1:0] r);
`ifdef PARITY_SCHED_RR_EN
    if (&r) return ~msrc[u];
`else
    if (&r) return 1'b0;
`endif
    return r[1];
  endfunction

  task automatic push(input int u, input logic [1:0] r,
                      input logic [3:0] d0, input logic [3:0] d1);
    exp_t e;
    logic w;
    w = pick(u, r);
    msrc[u] = w;
    e.g = w ? 2'b10 : 2'b01;
    e.nib = w ? d1 : d0;
    if (u == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic mon(input int u, input int bc, input logic [1:0] g,
                     input logic t, input logic d, input logic b,
                     input logic s);
    int k;
    logic want;
    logic ended;
    logic empty;
    ended = (act[u] != 0) && (pos[u] == 7 * bc);
    if (ended) begin
      chk("done", d, 1);
      chk("odd_ones", ones[u] % 2, 1);
      act[u] = 0;
    end else begin
      chk("no_done", d, 0);
    end
    if (g != 2'b00) begin
      empty = (u == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        chk("gnt_unexpected", g, 0);
      end else begin
        cur[u] = (u == 0) ? qa.pop_front() : qb.pop_front();
        chk("gnt", g, cur[u].g);
        chk("src", s, cur[u].g[1]);
        act[u] = 1;
        pos[u] = 0;
        ones[u] = 0;
      end
    end
    if (act[u] != 0) begin
      k = pos[u] / bc;
      case (k)
        0: want = 1'b0;
        1, 2, 3, 4: want = cur[u].nib[k-1];
        5: want = ~^cur[u].nib;
        default: want = 1'b1;
      endcase
      chk("tx", t, want);
      chk("busy", b, 1);
      if ((pos[u] % bc == 0) && k >= 1 && k <= 5) ones[u] += int'(t);
      pos[u]++;
    end else begin
      chk("idle_tx", t, 1);
      chk("idle_busy", b, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      act[0] = 0;
      act[1] = 0;
    end else begin
      mon(0, BA, ia.gnt, ia.tx, ia.done, ia.busy, ia.src);
      mon(1, BB, ib.gnt, ib.tx, ib.done, ib.busy, ib.src);
    end
  end

  task automatic wait_gnt_a(input int i);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ia.gnt[i] && n < 300);
    if (!ia.gnt[i]) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (ia.busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", ia.busy, 0);
  endtask

  int prev;
  int n;

  initial begin
    act[0] = 0;
    act[1] = 0;
    msrc[0] = 1'b1;
    msrc[1] = 1'b1;
    ia.req = 2'b00; ia.data0 = 4'h0; ia.data1 = 4'h0;
    ib.req = 2'b00; ib.data0 = 4'h0; ib.data1 = 4'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", ia.tx, 1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_gnt", ia.gnt, 0);
    chk("rst_src", ia.src, 1);
    chk("rst_src_b", ib.src, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    ia.data0 = 4'b0000;
    push(0, 2'b01, ia.data0, ia.data1);
    ia.req = 2'b01;
    wait_gnt_a(0);
    ia.req = 2'b00;
    wait_idle_a();

    ib.data1 = 4'b0111;
    push(1, 2'b10, ib.data0, ib.data1);
    ib.req = 2'b10;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ib.gnt[1] && n < 300);
    ib.req = 2'b00;
    chk("b_gnt_seen", ib.gnt, 2'b10);
    repeat (7 * BB) @(posedge clk);
    #1;
    chk("b_src", ib.src, 1);
    chk("b_idle", ib.busy, 0);

    ia.data0 = 4'h5;
    ia.data1 = 4'hA;
    for (int f = 0; f < 4; f++) push(0, 2'b11, ia.data0, ia.data1);
    ia.req = 2'b11;
    prev = 0;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (ia.gnt == 2'b00 && n < 300);
      if (ia.gnt == 2'b00) chk("b2b_timeout", 0, 1);
      if (f > 0) chk("b2b_gap", cyc - prev, 7 * BA);
      prev = cyc;
    end
    ia.req = 2'b00;
    wait_idle_a();

    ia.data0 = 4'b1111;
    push(0, 2'b01, ia.data0, ia.data1);
    ia.req = 2'b01;
    wait_gnt_a(0);
    ia.req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    ia.data1 = 4'b0011;
    push(0, 2'b10, ia.data0, ia.data1);
    ia.req = 2'b10;
    wait_gnt_a(1);
    chk("gnt_with_done", ia.done, 1);
    ia.req = 2'b00;
    wait_idle_a();

    ia.data0 = 4'b1010;
    push(0, 2'b01, ia.data0, ia.data1);
    ia.req = 2'b01;
    wait_gnt_a(0);
    ia.req = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    msrc[0] = 1'b1;
    msrc[1] = 1'b1;
    #1;
    chk("abort_tx", ia.tx, 1);
    chk("abort_busy", ia.busy, 0);
    chk("abort_done", ia.done, 0);
    chk("abort_gnt", ia.gnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ia.data0 = 4'b0110;
    push(0, 2'b01, ia.data0, ia.data1);
    ia.req = 2'b01;
    wait_gnt_a(0);
    ia.req = 2'b00;
    wait_idle_a();

    for (int v = 0; v < 16; v++) begin
      ia.data0 = 4'(v);
      push(0, 2'b01, ia.data0, ia.data1);
      ia.req = 2'b01;
      wait_gnt_a(0);
      ia.req = 2'b00;
    end
    wait_idle_a();
    repeat (4) @(posedge clk);
    #1;

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
